// File: rtl/tdm_tx_serializer_if.sv
// Sample handshake between the transmit FIFO and the TDM serializer.
// ch_idx tells the source which channel the next accepted sample belongs to.
interface tdm_tx_serializer_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 24
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [CH_W-1:0]   ch_idx;

  modport master (output s_data, output s_valid, input s_ready, input ch_idx);
  modport slave  (input s_data, input s_valid, output s_ready, output ch_idx);
endinterface

// File: rtl/tdm_tx_serializer.sv
// TDM / I2S transmit serializer: NUM_CH slots per frame on sd, with sclk and ws
// derived from pclk. Philips, MSB- and LSB-justified framing, 50% or pulse sync.
module tdm_tx_serializer #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SLOT_W = 32,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DIV_W  = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       standard,
  input  logic             fsync_mode,
  tdm_tx_serializer_if.slave tx,
  input  logic             underrun_clr,
  output logic             underrun,
  output logic             busy,
  output logic             sclk,
  output logic             ws,
  output logic             sd
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned BIT_W = $clog2(SLOT_W);
  localparam int unsigned PAD_W = SLOT_W - DATA_W;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  HALF_CH  = CH_W'(NUM_CH / 2);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_W - 1);
  localparam logic [1:0]       STD_MSB  = 2'd1;
  localparam logic [1:0]       STD_LSB  = 2'd2;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               hold_empty_q, hold_empty_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               underrun_q, underrun_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         std_q, std_d;
  logic               fs_q, fs_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               sclk_q, sclk_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic [CH_W-1:0]    slot_q, slot_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [SLOT_W-1:0]  shreg_q, shreg_d;
  logic [SLOT_W-1:0]  load_word;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    next_ch = (c == LAST_CH) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [SLOT_W-1:0] slot_word(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] std);
    slot_word = (std == STD_LSB) ? SLOT_W'(d) : (SLOT_W'(d) << PAD_W);
  endfunction

  // Philips framing runs ws one bit ahead, so evaluate it at the following bit position.
  function automatic logic ws_at(input logic [CH_W-1:0] slot, input logic [BIT_W-1:0] bidx,
                                 input logic [1:0] std, input logic fs);
    logic [CH_W-1:0]  es;
    logic [BIT_W-1:0] eb;
    es = slot;
    eb = bidx;
    if (std != STD_MSB && std != STD_LSB) begin
      if (bidx == LAST_BIT) begin
        eb = '0;
        es = next_ch(slot);
      end else begin
        eb = bidx + 1'b1;
      end
    end
    ws_at = fs ? (es == '0 && eb == '0) : (es >= HALF_CH);
  endfunction

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    hold_empty_d = hold_empty_q;
    hold_data_d  = hold_data_q;
    ch_d         = ch_q;
    underrun_d   = underrun_q;
    div_d        = div_q;
    std_d        = std_q;
    fs_d         = fs_q;
    cnt_d        = cnt_q;
    sclk_d       = sclk_q;
    ws_d         = ws_q;
    sd_d         = sd_q;
    slot_d       = slot_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    load_word    = '0;

    if (tx.s_valid && hold_empty_q) begin
      hold_data_d  = tx.s_data;
      hold_empty_d = 1'b0;
      ch_d         = next_ch(ch_q);
    end
    if (underrun_clr) underrun_d = 1'b0;

    case (state_q)
      // The start cycle acts as the falling event that presents slot 0 bit 0.
      ST_IDLE: begin
        if (en && !hold_empty_q) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          div_d        = div;
          std_d        = standard;
          fs_d         = fsync_mode;
          cnt_d        = '0;
          sclk_d       = 1'b0;
          slot_d       = '0;
          bit_d        = '0;
          load_word    = slot_word(hold_data_q, standard);
          hold_empty_d = 1'b1;
          shreg_d      = load_word;
          sd_d         = load_word[SLOT_W-1];
          ws_d         = ws_at('0, '0, standard, fsync_mode);
        end
      end
      ST_RUN: begin
        if (cnt_q != div_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (slot_q == LAST_CH && bit_q == LAST_BIT && !en) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              sclk_d  = 1'b0;
              ws_d    = 1'b0;
              sd_d    = 1'b0;
            end else begin
              if (bit_q == LAST_BIT) begin
                bit_d  = '0;
                slot_d = next_ch(slot_q);
                // Slot load: hold first, then a same-cycle bypass, else a zero slot.
                if (!hold_empty_q) begin
                  load_word    = slot_word(hold_data_q, std_q);
                  hold_empty_d = 1'b1;
                end else if (tx.s_valid) begin
                  load_word    = slot_word(tx.s_data, std_q);
                  hold_empty_d = 1'b1;
                end else begin
                  underrun_d = 1'b1;
                  ch_d       = next_ch(ch_q);
                end
                shreg_d = load_word;
                sd_d    = load_word[SLOT_W-1];
              end else begin
                bit_d   = bit_q + 1'b1;
                shreg_d = shreg_q << 1;
                sd_d    = shreg_q[SLOT_W-2];
              end
              ws_d = ws_at(slot_d, bit_d, std_q, fs_q);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      hold_empty_q <= 1'b1;
      hold_data_q  <= '0;
      ch_q         <= '0;
      underrun_q   <= 1'b0;
      div_q        <= '0;
      std_q        <= '0;
      fs_q         <= 1'b0;
      cnt_q        <= '0;
      sclk_q       <= 1'b0;
      ws_q         <= 1'b0;
      sd_q         <= 1'b0;
      slot_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      hold_empty_q <= hold_empty_d;
      hold_data_q  <= hold_data_d;
      ch_q         <= ch_d;
      underrun_q   <= underrun_d;
      div_q        <= div_d;
      std_q        <= std_d;
      fs_q         <= fs_d;
      cnt_q        <= cnt_d;
      sclk_q       <= sclk_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      slot_q       <= slot_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
    end
  end

  assign tx.s_ready = hold_empty_q;
  assign tx.ch_idx  = ch_q;
  assign underrun   = underrun_q;
  assign busy       = busy_q;
  assign sclk       = sclk_q;
  assign ws         = ws_q;
  assign sd         = sd_q;
endmodule

// File: tb/tb_tdm_tx_serializer.sv
// Directed bench for tdm_tx_serializer: a 2-channel instance for framing, underrun,
// stop and reset behaviour, and an 8-channel pulse-sync instance.
module tb_tdm_tx_serializer;
  localparam int unsigned SLOT_W = 32;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned DIV_W  = 8;

  logic pclk = 1'b0;
  logic preset;
  logic en_a, fs_a, clr_a, underrun_a, busy_a, sclk_a, ws_a, sd_a;
  logic en_b, fs_b, clr_b, underrun_b, busy_b, sclk_b, ws_b, sd_b;
  logic [DIV_W-1:0] div_a, div_b;
  logic [1:0] std_a, std_b;

  int n_vec = 0;
  int n_err = 0;

  tdm_tx_serializer_if #(.NUM_CH(2), .DATA_W(DATA_W)) if_a ();
  tdm_tx_serializer_if #(.NUM_CH(8), .DATA_W(DATA_W)) if_b ();

  tdm_tx_serializer #(.NUM_CH(2), .SLOT_W(SLOT_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut_a (
    .pclk(pclk), .preset(preset), .en(en_a), .div(div_a), .standard(std_a),
    .fsync_mode(fs_a), .tx(if_a), .underrun_clr(clr_a), .underrun(underrun_a),
    .busy(busy_a), .sclk(sclk_a), .ws(ws_a), .sd(sd_a));

  tdm_tx_serializer #(.NUM_CH(8), .SLOT_W(SLOT_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut_b (
    .pclk(pclk), .preset(preset), .en(en_b), .div(div_b), .standard(std_b),
    .fsync_mode(fs_b), .tx(if_b), .underrun_clr(clr_b), .underrun(underrun_b),
    .busy(busy_b), .sclk(sclk_b), .ws(ws_b), .sd(sd_b));

  always #5 pclk = ~pclk;

  // Bit capture on each sclk rise, i.e. where a receiver would sample.
  bit   cap_sd [0:1023];
  bit   cap_ws [0:1023];
  int   na = 0;
  logic sclk_a_q = 1'b0;
  time  t_prev = 0;
  time  per_a = 0;
  always @(negedge pclk) begin
    if (sclk_a && !sclk_a_q && na < 1024) begin
      cap_sd[na] = sd_a;
      cap_ws[na] = ws_a;
      na++;
      per_a  = $time - t_prev;
      t_prev = $time;
    end
    sclk_a_q = sclk_a;
  end

  int   nb = 0;
  int   ws_b_pos[$];
  logic sclk_b_q = 1'b0;
  always @(negedge pclk) begin
    if (sclk_b && !sclk_b_q) begin
      if (ws_b) ws_b_pos.push_back(nb);
      nb++;
    end
    sclk_b_q = sclk_b;
  end

  function automatic logic [31:0] wd(input bit use_ws, input int base);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = use_ws ? cap_ws[base+i] : cap_sd[base+i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [DATA_W-1:0] d);
    int n = 0;
    @(negedge pclk);
    if_a.s_data  = d;
    if_a.s_valid = 1'b1;
    while (!if_a.s_ready && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    chk("push_a accept", 64'(if_a.s_ready), 64'd1);
    @(negedge pclk);
    if_a.s_valid = 1'b0;
  endtask

  task automatic push_b(input logic [DATA_W-1:0] d, input int exp_ch);
    int n = 0;
    @(negedge pclk);
    if_b.s_data  = d;
    if_b.s_valid = 1'b1;
    while (!if_b.s_ready && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    chk("push_b ch_idx", 64'(if_b.ch_idx), 64'(exp_ch));
    @(negedge pclk);
    if_b.s_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 5000) begin
      @(negedge pclk);
      n++;
    end
    chk("a frame stop", 64'(busy_a), 64'd0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (busy_b && n < 5000) begin
      @(negedge pclk);
      n++;
    end
    chk("b frame stop", 64'(busy_b), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    preset = 1'b1;
    en_a = 1'b0; div_a = 8'd1; std_a = 2'd1; fs_a = 1'b0; clr_a = 1'b0;
    en_b = 1'b0; div_b = 8'd0; std_b = 2'd1; fs_b = 1'b1; clr_b = 1'b0;
    if_a.s_valid = 1'b0; if_a.s_data = '0;
    if_b.s_valid = 1'b0; if_b.s_data = '0;
    #23 preset = 1'b0;
    @(negedge pclk);
    chk("reset s_ready", 64'(if_a.s_ready), 64'd1);
    chk("reset pins", 64'({sclk_a, ws_a, sd_a, busy_a, underrun_a, if_a.ch_idx}), 64'd0);

    // MSB-justified, 50% ws, div=1
    base = na;
    push_a(24'hABCDEF);
    @(negedge pclk) en_a = 1'b1;
    push_a(24'h123456);
    @(negedge pclk) en_a = 1'b0;
    wait_idle_a();
    chk("msb bits", 64'(na - base), 64'd64);
    chk("msb sd slot0", 64'(wd(0, base)), 64'hABCDEF00);
    chk("msb sd slot1", 64'(wd(0, base + 32)), 64'h12345600);
    chk("msb ws slot0", 64'(wd(1, base)), 64'h0);
    chk("msb ws slot1", 64'(wd(1, base + 32)), 64'hFFFFFFFF);
    chk("sclk period", 64'(per_a), 64'd40);
    chk("msb underrun/ch", 64'({underrun_a, if_a.ch_idx}), 64'd0);
    chk("idle pins", 64'({sclk_a, ws_a, sd_a}), 64'd0);

    // Philips: ws edges one bit early, two frames
    std_a = 2'd0;
    base = na;
    push_a(24'h111111);
    @(negedge pclk) en_a = 1'b1;
    push_a(24'h222222);
    push_a(24'h333333);
    push_a(24'h444444);
    @(negedge pclk) en_a = 1'b0;
    wait_idle_a();
    chk("phil bits", 64'(na - base), 64'd128);
    chk("phil ws f1s0", 64'(wd(1, base)), 64'h00000001);
    chk("phil ws f1s1", 64'(wd(1, base + 32)), 64'hFFFFFFFE);
    chk("phil ws f2s0", 64'(wd(1, base + 64)), 64'h00000001);
    chk("phil sd f1s1", 64'(wd(0, base + 32)), 64'h22222200);
    chk("phil sd f2s1", 64'(wd(0, base + 96)), 64'h44444400);
    chk("phil underrun", 64'(underrun_a), 64'd0);

    // LSB-justified
    std_a = 2'd2;
    base = na;
    push_a(24'hC0FFEE);
    @(negedge pclk) en_a = 1'b1;
    push_a(24'h5A5A5A);
    @(negedge pclk) en_a = 1'b0;
    wait_idle_a();
    chk("lsb sd slot0", 64'(wd(0, base)), 64'h00C0FFEE);
    chk("lsb sd slot1", 64'(wd(0, base + 32)), 64'h005A5A5A);
    chk("lsb ws slot1", 64'(wd(1, base + 32)), 64'hFFFFFFFF);

    // Underrun on slot 1, clear, then clear coinciding with a new underrun
    std_a = 2'd1;
    base = na;
    push_a(24'h777777);
    @(negedge pclk) en_a = 1'b1;
    @(negedge pclk) en_a = 1'b0;
    wait_idle_a();
    chk("ur sd slot0", 64'(wd(0, base)), 64'h77777700);
    chk("ur sd slot1", 64'(wd(0, base + 32)), 64'h0);
    chk("ur flag", 64'(underrun_a), 64'd1);
    chk("ur ch_idx", 64'(if_a.ch_idx), 64'd0);
    @(negedge pclk) clr_a = 1'b1;
    @(negedge pclk) clr_a = 1'b0;
    chk("ur cleared", 64'(underrun_a), 64'd0);
    push_a(24'h888888);
    @(negedge pclk) en_a = 1'b1;
    @(negedge pclk);
    chk("ur2 start", 64'(busy_a), 64'd1);
    en_a = 1'b0;
    repeat (127) @(negedge pclk);
    clr_a = 1'b1;
    @(negedge pclk);
    clr_a = 1'b0;
    chk("ur set wins", 64'(underrun_a), 64'd1);
    wait_idle_a();
    chk("ur2 ch_idx", 64'(if_a.ch_idx), 64'd0);

    // 8-channel pulse sync, two frames
    push_b(24'h000100, 0);
    @(negedge pclk) en_b = 1'b1;
    for (int k = 1; k < 16; k++) push_b(24'h000100 + 24'(k), k % 8);
    @(negedge pclk) en_b = 1'b0;
    wait_idle_b();
    chk("tdm bits", 64'(nb), 64'd512);
    chk("tdm pulses", 64'(ws_b_pos.size()), 64'd2);
    if (ws_b_pos.size() == 2) begin
      chk("tdm pulse0 pos", 64'(ws_b_pos[0]), 64'd0);
      chk("tdm pulse1 pos", 64'(ws_b_pos[1]), 64'd256);
    end
    chk("tdm ch_idx/ur", 64'({if_b.ch_idx, underrun_b}), 64'd0);
    chk("tdm idle pins", 64'({sclk_b, ws_b, sd_b}), 64'd0);

    // en dropped at slot 0 bit 5: stop after slot 1 bit 31
    base = na;
    push_a(24'h13579B);
    @(negedge pclk) en_a = 1'b1;
    @(negedge pclk);
    chk("stop start", 64'(busy_a), 64'd1);
    repeat (21) @(negedge pclk);
    en_a = 1'b0;
    n = 21;
    while (busy_a && n < 1000) begin
      @(negedge pclk);
      n++;
    end
    chk("stop cycle", 64'(n), 64'd256);
    chk("stop bits", 64'(na - base), 64'd64);
    chk("stop pins", 64'({sclk_a, ws_a, sd_a, busy_a}), 64'd0);

    // Asynchronous reset mid-frame
    push_a(24'h2468AC);
    @(negedge pclk) en_a = 1'b1;
    push_a(24'h0F0F0F);
    repeat (50) @(negedge pclk);
    chk("pre-reset state", 64'({busy_a, if_a.s_ready, underrun_a}), 64'b101);
    #2 preset = 1'b1;
    #1;
    chk("async reset pins", 64'({sclk_a, ws_a, sd_a, busy_a, underrun_a, if_a.ch_idx}), 64'd0);
    chk("async reset s_ready", 64'(if_a.s_ready), 64'd1);
    en_a = 1'b0;
    @(negedge pclk) preset = 1'b0;
    repeat (4) @(negedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tdm_tx_serializer.md
Name: tdm_tx_serializer

Overview:
Parametrised successor to the stereo I2S transmit path. It serialises NUM_CH channel samples per frame onto sd and generates sclk and ws from a single pclk. It supports Philips, MSB-justified and LSB-justified alignment, plus 50%-duty or one-bit-pulse frame sync (TDM). Samples arrive through a one-entry holding register with a valid/ready handshake; it sits between the transmit FIFO and the pins.

Parameters:
NUM_CH, 2, channels (slots) per frame, 2..16; must be even when fsync_mode=0.
SLOT_W, 32, sclk bits per slot, 8..32.
DATA_W, 24, sample width, must be <= SLOT_W.
DIV_W, 8, width of the clock-divider setting.

Ports:
pclk  in  1  system clock.
preset  in  1  asynchronous active-high reset.
en  in  1  transmit enable.
div  in  DIV_W  sclk half-period in pclk cycles minus 1.
standard  in  2  0 = Philips, 1 = MSB-justified, 2 = LSB-justified, 3 = treated as Philips.
fsync_mode  in  1  0 = 50% ws, 1 = one-bit ws pulse per frame.
s_data  in  DATA_W  sample to transmit.
s_valid  in  1  s_data valid.
s_ready  out  1  holding register empty.
ch_idx  out  $clog2(NUM_CH)  channel number of the next sample accepted.
underrun_clr  in  1  clears the underrun flag.
underrun  out  1  sticky: a slot was loaded with no sample available.
busy  out  1  frame generation active.
sclk  out  1  serial bit clock.
ws  out  1  word select / frame sync.
sd  out  1  serial data, MSB first.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): sclk=0, ws=0, sd=0, busy=0, underrun=0, ch_idx=0, hold emptied, so s_ready=1. Partial frame content is discarded.
- s_ready = !hold_valid. A handshake (s_valid & s_ready) loads hold and increments ch_idx, wrapping from NUM_CH-1 to 0.
- Frame start: when idle with en=1 and hold_valid=1, busy goes to 1 and div, standard and fsync_mode are latched. Changes to these inputs while busy take effect only at the next frame start.
- sclk: a divider counts 0..div and toggles sclk at terminal count. One bit period is 2*(div+1) pclk cycles; div=0 gives pclk/2.
- sd and ws are registered and update in the pclk cycle in which sclk falls. The receiver samples on sclk rising.
- Slot load happens at the falling event that starts bit 0 of each slot:
  - hold_valid: hold moves into the shift register and hold empties.
  - Hold empty with s_valid in that cycle: the sample bypasses hold into the shift register, with no underrun; ch_idx advances.
  - Hold empty with no s_valid: all zeros are loaded, underrun is set and ch_idx advances, so channel alignment is preserved.
- Slot word: MSB and Philips = {data, (SLOT_W-DATA_W) zeros}; LSB = {(SLOT_W-DATA_W) zeros, data}.
- ws, fsync_mode=0: ws=0 during slots 0..NUM_CH/2-1 and 1 during the rest. For Philips, each ws transition occurs one bit earlier, at bit SLOT_W-1 of the preceding slot, so wrap-around puts the frame's ws fall in the last bit of slot NUM_CH-1.
- ws, fsync_mode=1: ws=1 for exactly one bit per frame.
  - MSB/LSB: the pulse is on bit 0 of slot 0.
  - Philips: the pulse is on the last bit of slot NUM_CH-1, i.e. the bit before slot 0.
  - First frame after start in Philips mode: the early edge or pulse is not emitted.
- en deasserted while busy: the current frame completes through its last bit, then busy=0 and sclk, ws and sd are held at 0. Hold contents and ch_idx are retained. Re-enabling restarts at slot 0 with ch_idx unchanged.
- underrun_clr clears underrun. If a new underrun occurs in the same cycle, the set wins.
- Frames run back-to-back with no gap while en=1, regardless of hold state; underruns produce zero slots.

Test Plan:
1. NUM_CH=2, SLOT_W=32, DATA_W=24, div=1, MSB, fsync_mode=0; push 24'hABCDEF then 24'h123456 -> sclk period 4 pclk; ws=0 for 32 bits then 1 for 32 bits; sd = ABCDEF MSB-first plus 8 zeros, then 123456 plus 8 zeros; underrun=0.
2. Same configuration, standard=0 (Philips) -> second-slot ws rises at bit 31 of slot 0, one bit before 123456's MSB; from the second frame, ws falls at bit 31 of slot 1.
3. Same configuration, standard=2 (LSB) -> each slot has 8 zeros, then the 24 data bits ending on bit 31.
4. Push ch0 sample only -> slot 1 sd all zeros; underrun=1; ch_idx=0 afterwards. Pulse underrun_clr -> underrun=0. underrun_clr coinciding with a new underrun -> underrun stays 1.
5. NUM_CH=8, SLOT_W=32, fsync_mode=1, MSB; stream 8 samples per frame -> ws high for exactly 1 bit per 256-bit frame, on bit 0 of slot 0; ch_idx cycles 0..7.
6. Drop en at slot 0 bit 5 -> frame finishes at slot 1 bit 31, then busy=0 and sclk=ws=sd=0. Assert preset mid-frame -> all outputs 0 immediately and s_ready=1.
